prod_accum: RTL and testbench



---
 rtl/prod_accum_pkg.sv | 44 ++++
 rtl/prod_accum_acc_add_ovf.sv | 41 ++++
 rtl/prod_accum.sv | 132 +++++++++++++
 tb/tb_prod_accum.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prod_accum_pkg
// Purpose  : Shared types and helpers for the product accumulator.
//            - state_t : FSM encoding (ACCUM collects products, HOLD presents
//                        the finished dot product)
//            - sext    : sign extension of a PROD_W-wide product to MAX_W bits
//            - ACC_MAX / ACC_MIN : signed extremes at MAX_W bits; a narrower
//                        accumulator derives its own limits by shifting these
//                        down (logical for MAX, arithmetic for MIN)
//            - cnt_w   : width of a counter that holds 0..n
// Revision : 1.0 - initial release
// ============================================================================
package prod_accum_pkg;

  // Widest accumulator the block supports.
  localparam int MAX_W = 48;

  localparam logic        [MAX_W-1:0] ACC_MAX = {1'b0, {(MAX_W-1){1'b1}}};
  localparam logic signed [MAX_W-1:0] ACC_MIN = {1'b1, {(MAX_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Counter width able to represent the values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Sign-extend the low prod_w bits of prod to MAX_W bits: shift the sign bit
  // to the top, then arithmetic-shift back down.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] prod,
                                            input int unsigned     prod_w);
    logic signed [MAX_W-1:0] t;
    int unsigned             sh;
    sh = MAX_W - prod_w;
    t  = prod << sh;
    return t >>> sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prod_accum_acc_add_ovf.sv
`default_nettype none
// ============================================================================
// Module   : acc_add_ovf
// Purpose  : Combinational ACC_W-bit signed adder with overflow detection.
//            Overflow: both operands share a sign and the result sign differs.
//            Optional macro PROD_ACCUM_SATURATE_EN clamps the sum to the
//            signed extreme in the direction of the operands on overflow;
//            otherwise the sum wraps modulo 2^ACC_W.
// Ports    : a, b  - addends (ACC_W, signed)
//            sum   - result (ACC_W, wrapped or clamped)
//            ovf   - signed overflow of a + b
// Revision : 1.0 - initial release
// ============================================================================
module acc_add_ovf
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] w_raw;

  assign w_raw = a + b;
  assign ovf   = (a[ACC_W-1] == b[ACC_W-1]) && (w_raw[ACC_W-1] != a[ACC_W-1]);

`ifdef PROD_ACCUM_SATURATE_EN
  localparam logic [ACC_W-1:0] c_acc_max = ACC_W'(ACC_MAX >> (MAX_W - ACC_W));
  localparam logic [ACC_W-1:0] c_acc_min = ACC_W'(ACC_MIN >>> (MAX_W - ACC_W));

  // On overflow both operands have the sign of a, so it picks the rail.
  assign sum = ovf ? (a[ACC_W-1] ? c_acc_min : c_acc_max) : w_raw;
`else
  assign sum = w_raw;
`endif

endmodule
`default_nettype wire

// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : prod_accum
// Purpose  : Sums groups of N_TERMS signed products into a dot product and
//            holds the result, with a sticky per-group overflow flag, until
//            the downstream side accepts it.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            in_valid/in_ready  - product handshake (ready only in ACCUM)
//            in_prod            - PROD_W-bit signed product
//            out_valid/out_ready- result handshake (valid only in HOLD)
//            out_sum, out_ovf   - ACC_W-bit result and overflow flag
//            term_cnt           - products accepted in the current group
// Options  : PROD_ACCUM_SATURATE_EN - saturating instead of wrapping adds
// Revision : 1.0 - initial release
// ============================================================================
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PROD_W-1:0]            in_prod,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_sum,
  output logic                         out_ovf,
  output logic [cnt_w(N_TERMS)-1:0]    term_cnt
);

  localparam int                 c_cnt_w = cnt_w(N_TERMS);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N_TERMS - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [c_cnt_w-1:0] r_term_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_out_sum;
  logic               r_out_ovf;

  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic               w_accept;
  logic               w_last;

  assign w_prod_ext = ACC_W'(sext(MAX_W'(in_prod), PROD_W));

  acc_add_ovf #(
    .ACC_W (ACC_W)
  ) u_add (
    .a   (r_acc),
    .b   (w_prod_ext),
    .sum (w_sum),
    .ovf (w_add_ovf)
  );

  assign w_accept = in_valid & in_ready;
  assign w_last   = w_accept && (r_term_cnt == c_last);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (r_term_cnt == c_last)) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // Returning to ACCUM here means in_ready rises only on the next
        // cycle: no product is taken in the same cycle as the result.
        if (out_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  // --------------------------------------------------------------------------
  // Accumulator, counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_term_cnt <= '0;
      r_ovf      <= 1'b0;
      r_out_sum  <= '0;
      r_out_ovf  <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        // Final term: capture the result and start the next group clean.
        r_out_sum  <= w_sum;
        r_out_ovf  <= r_ovf | w_add_ovf;
        r_acc      <= '0;
        r_term_cnt <= '0;
        r_ovf      <= 1'b0;
      end else begin
        r_acc      <= w_sum;
        r_term_cnt <= r_term_cnt + c_one;
        r_ovf      <= r_ovf | w_add_ovf;
      end
    end
  end

  assign out_sum  = r_out_sum;
  assign out_ovf  = r_out_ovf;
  assign term_cnt = r_term_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_prod_accum
// Purpose  : Self-checking bench for prod_accum. Three instances cover
//            N_TERMS=4/ACC_W=24, N_TERMS=8/ACC_W=18 and N_TERMS=1. Expected
//            results are queued when a group is driven and compared when the
//            result handshake occurs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prod_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N_TERMS=4, ACC_W=24
  logic        iv4, ir4, ov4, or4, ovf4;
  logic [15:0] ip4;
  logic [23:0] os4;
  logic [2:0]  tc4;
  // N_TERMS=8, ACC_W=18
  logic        iv18, ir18, ov18, or18, ovf18;
  logic [15:0] ip18;
  logic [17:0] os18;
  logic [3:0]  tc18;
  // N_TERMS=1, ACC_W=24
  logic        iv1, ir1, ov1, or1, ovf1;
  logic [15:0] ip1;
  logic [23:0] os1;
  logic [0:0]  tc1;

  prod_accum #(.PROD_W(16), .ACC_W(24), .N_TERMS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_prod(ip4),
    .out_valid(ov4), .out_ready(or4), .out_sum(os4), .out_ovf(ovf4),
    .term_cnt(tc4));

  prod_accum #(.PROD_W(16), .ACC_W(18), .N_TERMS(8)) u_dut18 (
    .clk(clk), .rst(rst), .in_valid(iv18), .in_ready(ir18), .in_prod(ip18),
    .out_valid(ov18), .out_ready(or18), .out_sum(os18), .out_ovf(ovf18),
    .term_cnt(tc18));

  prod_accum #(.PROD_W(16), .ACC_W(24), .N_TERMS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_prod(ip1),
    .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_ovf(ovf1),
    .term_cnt(tc1));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    longint sum;
    logic   ovf;
  } exp_t;

  exp_t q4[$], q18[$], q1[$];
  exp_t e4, e18, e1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboards: a result is consumed when valid and ready meet.
  always @(negedge clk) begin
    if (!rst && ov4 && or4) begin
      if (q4.size() == 0) chk("u4_unexpected_result", 1, 0);
      else begin
        e4 = q4.pop_front();
        chk("u4_sum", $signed(os4), e4.sum);
        chk("u4_ovf", ovf4, e4.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov18 && or18) begin
      if (q18.size() == 0) chk("u18_unexpected_result", 1, 0);
      else begin
        e18 = q18.pop_front();
        chk("u18_sum", $signed(os18), e18.sum);
        chk("u18_ovf", ovf18, e18.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) chk("u1_unexpected_result", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("u1_sum", $signed(os1), e1.sum);
        chk("u1_ovf", ovf1, e1.ovf);
      end
    end
  end

  function automatic logic rdy(input int d);
    case (d)
      0:       return ir4;
      1:       return ir18;
      default: return ir1;
    endcase
  endfunction

  task automatic drive(input int d, input logic v, input int p);
    case (d)
      0:       begin iv4  = v; ip4  = 16'(p); end
      1:       begin iv18 = v; ip18 = 16'(p); end
      default: begin iv1  = v; ip1  = 16'(p); end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge,
  // then idles for gap cycles.
  task automatic send(input int d, input int p, input int gap);
    int t = 0;
    drive(d, 1'b1, p);
    @(negedge clk);
    while (!rdy(d)) begin
      t++;
      if (t > 40) begin
        chk("send_timeout", t, 0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    drive(d, 1'b0, 0);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g2[4];
    longint exp3;
    g2 = '{0, 3, 1, 0};

    rst = 1'b1;
    iv4 = 1'b0; ip4 = '0; or4 = 1'b0;
    iv18 = 1'b0; ip18 = '0; or18 = 1'b0;
    iv1 = 1'b0; ip1 = '0; or1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", ov4, 0);
    chk("rst_term_cnt", tc4, 0);
    chk("rst_out_sum", os4, 0);
    chk("rst_out_ovf", ovf4, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", ir4, 1);

    // Back-to-back group, immediate accept of the result.
    or4 = 1'b1;
    q4.push_back('{257, 1'b0});
    send(0, 100, 0);
    send(0, 200, 0);
    send(0, -50, 0);
    send(0, 7, 0);
    chk("t1_out_valid", ov4, 1);
    chk("t1_in_ready_low", ir4, 0);
    chk("t1_sum", $signed(os4), 257);
    @(posedge clk); #1;
    chk("t1_in_ready_back", ir4, 1);
    chk("t1_out_valid_clr", ov4, 0);

    // Negative extremes with idle gaps.
    q4.push_back('{-131072, 1'b0});
    for (int i = 0; i < 4; i++) begin
      chk("t2_term_cnt", tc4, i);
      send(0, -32768, g2[i]);
    end
    chk("t2_term_cnt_wrap", tc4, 0);
    chk("t2_sum", $signed(os4), -131072);
    @(posedge clk); #1;

    // Narrow accumulator overflow.
`ifdef PROD_ACCUM_SATURATE_EN
    exp3 = -131072;
`else
    exp3 = 0;
`endif
    or18 = 1'b1;
    q18.push_back('{exp3, 1'b1});
    for (int i = 0; i < 8; i++) send(1, -32768, 0);
    chk("t3_sum", $signed(os18), exp3);
    chk("t3_ovf", ovf18, 1);
    @(posedge clk); #1;

    // Back-pressure with a product waiting.
    or4 = 1'b0;
    q4.push_back('{10, 1'b0});
    send(0, 1, 0);
    send(0, 2, 0);
    send(0, 3, 0);
    send(0, 4, 0);
    drive(0, 1'b1, 99);
    q4.push_back('{102, 1'b0});
    for (int k = 0; k < 5; k++) begin
      chk("t4_in_ready_low", ir4, 0);
      chk("t4_out_valid", ov4, 1);
      chk("t4_sum_stable", $signed(os4), 10);
      @(posedge clk); #1;
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    chk("t4_in_ready", ir4, 1);
    chk("t4_term_cnt0", tc4, 0);
    @(posedge clk); #1;
    chk("t4_99_accepted", tc4, 1);
    drive(0, 1'b0, 0);
    send(0, 1, 0);
    send(0, 1, 0);
    send(0, 1, 0);
    @(posedge clk); #1;

    // Reset in the middle of a group.
    send(0, 100, 0);
    send(0, 200, 0);
    chk("t5_term_cnt_pre", tc4, 2);
    rst = 1'b1;
    #1;
    chk("t5_term_cnt", tc4, 0);
    chk("t5_out_valid", ov4, 0);
    chk("t5_out_sum", os4, 0);
    chk("t5_out_ovf", ovf4, 0);
    chk("t5_in_ready", ir4, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    q4.push_back('{4, 1'b0});
    for (int i = 0; i < 4; i++) send(0, 1, 0);
    @(posedge clk); #1;

    // Single-term groups alternate between ACCUM and HOLD.
    or1 = 1'b1;
    for (int i = 0; i < 3; i++) q1.push_back('{32767, 1'b0});
    drive(2, 1'b1, 32'h7FFF);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("t6_out_valid", ov1, k % 2);
      chk("t6_in_ready", ir1, 1 - (k % 2));
      if (k == 1) chk("t6_sum", $signed(os1), 32767);
    end
    drive(2, 1'b0, 0);

    repeat (3) begin @(posedge clk); #1; end
    chk("q4_drained", q4.size(), 0);
    chk("q18_drained", q18.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
